// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Shares the 1024 x 8 display frame-buffer RAM (synchronous read, one cycle
// of read latency, independent read and write addresses) between the LCD
// refresh reader and the CHIP-8 CPU, and provides a hardware clear engine
// for CLS.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   lcd_rd_*            LCD read client: req/addr in, gnt (comb), valid/data
//   cpu_rd_*            CPU read client: req/addr in, gnt (comb), valid/data
//   cpu_wr_*            CPU write client: req/addr/data in, gnt (comb)
//   clr_start           pulse that starts a full-buffer clear
//   clr_busy, clr_done  clear in progress / one-cycle completion pulse
//   ram_*               connections to the RAM instance
// ---------------------------------------------------------------------------
module fb_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lcd_rd_req,
    input  logic [ADDR_W-1:0] lcd_rd_addr,
    output logic              lcd_rd_gnt,
    output logic              lcd_rd_valid,
    output logic [DATA_W-1:0] lcd_rd_data,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_gnt,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_gnt,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0]   CLR_LAST   = ADDR_W'(DEPTH - 1);

    localparam logic ST_NORMAL = 1'b0;
    localparam logic ST_CLEAR  = 1'b1;

    logic                state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                in_clear;
    logic                cpu_forced;

    assign in_clear = (state == ST_CLEAR);
    assign clr_busy = in_clear;

    // The LCD normally wins the read port; a CPU that has been denied
    // STARVE_LIMIT cycles in a row takes it once. The clear engine owns the
    // write port only, so LCD reads keep flowing during a clear while CPU
    // reads are held off (the CPU must not observe a half-cleared buffer).
    assign cpu_forced = !in_clear && cpu_rd_req && (starve_cnt == STARVE_MAX);
    assign lcd_rd_gnt = lcd_rd_req && !cpu_forced;
    assign cpu_rd_gnt = !in_clear && cpu_rd_req && (cpu_forced || !lcd_rd_req);

    // The RAM samples its read address on the grant edge, so the granted
    // address is passed straight through; with no grant the last address is
    // held to avoid needless toggling of the RAM address bus.
    always_comb begin
        ram_read_address = rd_addr_q;
        if (lcd_rd_gnt) begin
            ram_read_address = lcd_rd_addr;
        end else if (cpu_rd_gnt) begin
            ram_read_address = cpu_rd_addr;
        end
    end

    // Remember the read address and which client owns the data coming back
    // next cycle; the two valid flops together act as the owner tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr_q    <= '0;
            lcd_rd_valid <= 1'b0;
            cpu_rd_valid <= 1'b0;
        end else begin
            rd_addr_q    <= ram_read_address;
            lcd_rd_valid <= lcd_rd_gnt;
            cpu_rd_valid <= cpu_rd_gnt;
        end
    end

    assign lcd_rd_data = ram_q;
    assign cpu_rd_data = ram_q;

    // Starvation counter: counts consecutive denied CPU read cycles and
    // saturates; frozen during a clear so the CPU keeps its place in line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!in_clear) begin
            if (!cpu_rd_req || cpu_rd_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    // Write port: the CPU passes straight through in NORMAL; during a clear
    // the engine writes zero to the current counter address every cycle.
    always_comb begin
        cpu_wr_gnt        = cpu_wr_req;
        ram_we            = cpu_wr_req;
        ram_write_address = cpu_wr_addr;
        ram_d             = cpu_wr_data;
        if (in_clear) begin
            cpu_wr_gnt        = 1'b0;
            ram_we            = 1'b1;
            ram_write_address = clr_cnt;
            ram_d             = '0;
        end
    end

    // Clear engine: one word per cycle from 0 up to DEPTH-1, then back to
    // NORMAL with a single-cycle clr_done. clr_start during a clear is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_NORMAL;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                ST_NORMAL: begin
                    if (clr_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state    <= ST_NORMAL;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter
// Self-checking bench for fb_arbiter with a behavioural 1024 x 8
// synchronous-read RAM attached. Table-driven arbitration vectors plus
// hand-written sequences for writes, the clear engine and reset mid-clear.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_rd_req;
    logic [9:0] lcd_rd_addr;
    logic       lcd_rd_gnt;
    logic       lcd_rd_valid;
    logic [7:0] lcd_rd_data;
    logic       cpu_rd_req;
    logic [9:0] cpu_rd_addr;
    logic       cpu_rd_gnt;
    logic       cpu_rd_valid;
    logic [7:0] cpu_rd_data;
    logic       cpu_wr_req;
    logic [9:0] cpu_wr_addr;
    logic [7:0] cpu_wr_data;
    logic       cpu_wr_gnt;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [9:0] ram_read_address;
    logic [7:0] ram_q;
    logic [9:0] ram_write_address;
    logic [7:0] ram_d;
    logic       ram_we;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .lcd_rd_req        (lcd_rd_req),
        .lcd_rd_addr       (lcd_rd_addr),
        .lcd_rd_gnt        (lcd_rd_gnt),
        .lcd_rd_valid      (lcd_rd_valid),
        .lcd_rd_data       (lcd_rd_data),
        .cpu_rd_req        (cpu_rd_req),
        .cpu_rd_addr       (cpu_rd_addr),
        .cpu_rd_gnt        (cpu_rd_gnt),
        .cpu_rd_valid      (cpu_rd_valid),
        .cpu_rd_data       (cpu_rd_data),
        .cpu_wr_req        (cpu_wr_req),
        .cpu_wr_addr       (cpu_wr_addr),
        .cpu_wr_data       (cpu_wr_data),
        .cpu_wr_gnt        (cpu_wr_gnt),
        .clr_start         (clr_start),
        .clr_busy          (clr_busy),
        .clr_done          (clr_done),
        .ram_read_address  (ram_read_address),
        .ram_q             (ram_q),
        .ram_write_address (ram_write_address),
        .ram_d             (ram_d),
        .ram_we            (ram_we)
    );

    // Behavioural frame-buffer RAM: read returns old data on a same-cycle
    // read/write collision.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_write_address] <= ram_d;
        end
        ram_q <= mem[ram_read_address];
    end

    typedef struct {
        logic       lcd_req;
        logic [9:0] lcd_addr;
        logic       cpu_req;
        logic [9:0] cpu_addr;
        logic       exp_lcd_gnt;
        logic       exp_cpu_gnt;
        logic       exp_lcd_valid;
        logic       exp_cpu_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        lcd_rd_req  = 1'b0;
        lcd_rd_addr = '0;
        cpu_rd_req  = 1'b0;
        cpu_rd_addr = '0;
        cpu_wr_req  = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        clr_start   = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        clear_inputs();
        lcd_rd_req  = v.lcd_req;
        lcd_rd_addr = v.lcd_addr;
        cpu_rd_req  = v.cpu_req;
        cpu_rd_addr = v.cpu_addr;
        #1;
    endtask

    task automatic write_word(input logic [9:0] addr, input logic [7:0] data);
        @(negedge clk);
        clear_inputs();
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = addr;
        cpu_wr_data = data;
        #1;
        check_output($sformatf("wrGnt@%0h", addr), {31'd0, cpu_wr_gnt}, 32'd1);
        check_output($sformatf("wrWe@%0h", addr), {31'd0, ram_we}, 32'd1);
    endtask

    task automatic fill_all(input logic [7:0] data);
        for (int a = 0; a < 1024; a++) begin
            @(negedge clk);
            clear_inputs();
            cpu_wr_req  = 1'b1;
            cpu_wr_addr = 10'(a);
            cpu_wr_data = data;
        end
    endtask

    task automatic cpu_read(input logic [9:0] addr, input logic [7:0] exp, input string name);
        @(negedge clk);
        clear_inputs();
        cpu_rd_req  = 1'b1;
        cpu_rd_addr = addr;
        #1;
        check_output({name, "Gnt"}, {31'd0, cpu_rd_gnt}, 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check_output({name, "Valid"}, {31'd0, cpu_rd_valid}, 32'd1);
        check_output({name, "Data"}, {24'd0, cpu_rd_data}, {24'd0, exp});
    endtask

    initial begin
        int busy_cycles;
        int done_seen;
        int bad_gnt;
        int bad_we;
        int bad_lcd;
        int bad_sweep;
        int k;

        // Arbitration table: LCD always at 0x010 (0xAA), CPU at 0x020 (0x55).
        // Valid/data columns describe the grant made in the previous row.
        vecs[0]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[2]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[3]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[4]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[5]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[6]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[7]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[8]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[9]  = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[10] = '{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
        // CPU-only read at 0x3FF (0x81), then idle.
        vecs[11] = '{1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[12] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};
        vecs[13] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state.
        reset = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        #1;
        check_output("rstBusy", {31'd0, clr_busy}, 32'd0);
        check_output("rstDone", {31'd0, clr_done}, 32'd0);
        check_output("rstLcdValid", {31'd0, lcd_rd_valid}, 32'd0);
        check_output("rstCpuValid", {31'd0, cpu_rd_valid}, 32'd0);
        check_output("rstWe", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Preload.
        write_word(10'h010, 8'hAA);
        write_word(10'h020, 8'h55);
        write_word(10'h3FF, 8'h81);
        write_word(10'h0F0, 8'h00);

        // Table-driven arbitration.
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d.lcdGnt", i), {31'd0, lcd_rd_gnt}, {31'd0, vecs[i].exp_lcd_gnt});
            check_output($sformatf("v%0d.cpuGnt", i), {31'd0, cpu_rd_gnt}, {31'd0, vecs[i].exp_cpu_gnt});
            check_output($sformatf("v%0d.lcdValid", i), {31'd0, lcd_rd_valid}, {31'd0, vecs[i].exp_lcd_valid});
            check_output($sformatf("v%0d.cpuValid", i), {31'd0, cpu_rd_valid}, {31'd0, vecs[i].exp_cpu_valid});
            if (vecs[i].exp_lcd_valid)
                check_output($sformatf("v%0d.lcdData", i), {24'd0, lcd_rd_data}, {24'd0, vecs[i].exp_data});
            if (vecs[i].exp_cpu_valid)
                check_output($sformatf("v%0d.cpuData", i), {24'd0, cpu_rd_data}, {24'd0, vecs[i].exp_data});
        end

        // Write then read the following cycle.
        write_word(10'h0F0, 8'hFF);
        cpu_read(10'h0F0, 8'hFF, "rdAfterWr");

        // Same-cycle read and write: read sees the old value.
        write_word(10'h0F0, 8'h00);
        @(negedge clk);
        clear_inputs();
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = 10'h0F0;
        cpu_wr_data = 8'h3C;
        cpu_rd_req  = 1'b1;
        cpu_rd_addr = 10'h0F0;
        #1;
        check_output("rwSameWrGnt", {31'd0, cpu_wr_gnt}, 32'd1);
        check_output("rwSameRdGnt", {31'd0, cpu_rd_gnt}, 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check_output("rwSameValid", {31'd0, cpu_rd_valid}, 32'd1);
        check_output("rwSameData", {24'd0, cpu_rd_data}, 32'h00);
        cpu_read(10'h0F0, 8'h3C, "rwSameAfter");

        // Full clear with LCD traffic and blocked CPU requests.
        fill_all(8'hFF);
        @(negedge clk);
        clear_inputs();
        clr_start   = 1'b1;
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = 10'h005;
        cpu_wr_data = 8'hFF;
        #1;
        check_output("wrWithStart", {31'd0, cpu_wr_gnt}, 32'd1);
        busy_cycles = 0;
        done_seen   = 0;
        bad_gnt     = 0;
        bad_we      = 0;
        bad_lcd     = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            clear_inputs();
            lcd_rd_req  = 1'b1;
            lcd_rd_addr = 10'h3FF;
            cpu_rd_req  = 1'b1;
            cpu_rd_addr = 10'h010;
            cpu_wr_req  = 1'b1;
            cpu_wr_addr = 10'h000;
            cpu_wr_data = 8'h00;
            clr_start   = (i == 10);
            #1;
            if (!clr_busy) begin
                lcd_rd_req = 1'b0;
                #1;
                check_output("doneAfterClear", {31'd0, clr_done}, 32'd1);
                check_output("cpuWrAfterClear", {31'd0, cpu_wr_gnt}, 32'd1);
                check_output("cpuRdAfterClear", {31'd0, cpu_rd_gnt}, 32'd1);
                break;
            end
            busy_cycles++;
            if (clr_done) done_seen++;
            if (cpu_wr_gnt || cpu_rd_gnt) bad_gnt++;
            if (!ram_we || ram_d != 8'h00) bad_we++;
            if (!lcd_rd_gnt || (i > 0 && !lcd_rd_valid)) bad_lcd++;
        end
        check_output("busyCycles", busy_cycles, 32'd1024);
        check_output("doneWhileBusy", done_seen, 32'd0);
        check_output("cpuGntInClear", bad_gnt, 32'd0);
        check_output("clearWrites", bad_we, 32'd0);
        check_output("lcdInClear", bad_lcd, 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check_output("donePulseEnd", {31'd0, clr_done}, 32'd0);

        // Sweep every location through the LCD port.
        bad_sweep = 0;
        for (int a = 0; a <= 1024; a++) begin
            @(negedge clk);
            clear_inputs();
            if (a < 1024) begin
                lcd_rd_req  = 1'b1;
                lcd_rd_addr = 10'(a);
            end
            #1;
            if (a > 0 && (!lcd_rd_valid || lcd_rd_data !== 8'h00)) begin
                if (bad_sweep == 0) $display("[TB] first non-zero location %0d", a - 1);
                bad_sweep++;
            end
        end
        check_output("clearSweep", bad_sweep, 32'd0);

        // Reset in the middle of a clear (counter at 500).
        fill_all(8'hFF);
        @(negedge clk);
        clear_inputs();
        clr_start = 1'b1;
        k = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            if (clr_busy) k++;
            if (k == 501) break;
        end
        check_output("busyBeforeReset", k, 32'd501);
        reset = 1'b0;
        #1;
        check_output("busyAfterReset", {31'd0, clr_busy}, 32'd0);
        check_output("doneAfterReset", {31'd0, clr_done}, 32'd0);
        check_output("weAfterReset", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (clr_done || clr_busy) done_seen++;
        end
        check_output("noDoneAfterReset", done_seen, 32'd0);
        cpu_read(10'd499, 8'h00, "mid499");
        cpu_read(10'd500, 8'hFF, "mid500");
        cpu_read(10'd600, 8'hFF, "mid600");

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
